// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its hazard checks.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  // Instruction field bit ranges: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS_HI  = 7;
  localparam int unsigned RS_LO  = 4;
  localparam int unsigned RT_HI  = 3;
  localparam int unsigned RT_LO  = 0;

  localparam logic [3:0] OP_LW    = 4'hA;
  localparam logic [3:0] OP_SW    = 4'hB;
  localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the ID instruction reads the register a load in EX writes.
module hazard_detect #(
  parameter logic [3:0] OP_LW = pipe_ctrl_pkg::OP_LW,
  parameter logic [3:0] OP_SW = pipe_ctrl_pkg::OP_SW
) (
  input  logic [15:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  output logic        load_use
);
  import pipe_ctrl_pkg::*;

  logic [3:0] w_op;
  logic [3:0] w_rs;
  logic [3:0] w_rt;
  logic       w_uses_rt;
  logic       w_unused_rd;

  assign w_op = id_inst[OPC_HI:OPC_LO];
  assign w_rs = id_inst[RS_HI:RS_LO];
  assign w_rt = id_inst[RT_HI:RT_LO];
  // rd is a destination only; it never participates in a read hazard
  assign w_unused_rd = ^id_inst[RD_HI:RD_LO];

  // ALU-format ops (opcode[3]=0) and stores read rt; a load only reads rs
  always_comb begin
    w_uses_rt = ((w_op[3] == 1'b0) && (w_op != OP_LW)) || (w_op == OP_SW);
    load_use  = id_valid && ex_is_load && (ex_rd != REG_ZERO) &&
                ((ex_rd == w_rs) || (w_uses_rt && (ex_rd == w_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freeze and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_DELAY   = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [3:0]  OP_LW        = pipe_ctrl_pkg::OP_LW,
  parameter logic [3:0]  OP_SW        = pipe_ctrl_pkg::OP_SW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        stall,
  output logic        pc_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic        freeze,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);
  import pipe_ctrl_pkg::*;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [2:0]  w_next_cnt;
  logic [15:0] r_stall_count;
  logic        w_load_use;
  logic        w_stall;
  logic        w_pc_write;
  logic        w_bubble;
  logic        w_flush;
  logic        w_freeze;

  hazard_detect #(
    .OP_LW (OP_LW),
    .OP_SW (OP_SW)
  ) u_hazard_detect (
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .load_use   (w_load_use)
  );

  // State and remaining-cycle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state and Mealy control outputs; mem_busy overrides everything and holds state/cnt
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    w_pc_write   = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_freeze     = 1'b0;
    if (mem_busy) begin
      w_stall  = 1'b1;
      w_freeze = 1'b1;
      if (r_state == RUN) w_next_state = MEM_WAIT;
    end else begin
      unique case (r_state)
        RUN: begin
          if (branch_taken) begin
            w_flush    = 1'b1;
            w_pc_write = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_next_state = FLUSH;
              w_next_cnt   = 3'(FLUSH_CYCLES - 2);
            end
          end else if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LOAD_DELAY > 1) begin
              w_next_state = LU_STALL;
              w_next_cnt   = 3'(LOAD_DELAY - 2);
            end
          end else begin
            w_pc_write = 1'b1;
          end
        end
        MEM_WAIT: begin
          w_pc_write   = 1'b1;
          w_next_state = RUN;
        end
        LU_STALL: begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (r_cnt == '0) w_next_state = RUN;
          else             w_next_cnt   = r_cnt - 3'd1;
        end
        FLUSH: begin
          w_flush    = 1'b1;
          w_pc_write = 1'b1;
          if (r_cnt == '0) w_next_state = RUN;
          else             w_next_cnt   = r_cnt - 3'd1;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  // Saturating count of cycles spent with stall asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall       = w_stall    & rst;
  assign pc_write    = w_pc_write & rst;
  assign idex_bubble = w_bubble   & rst;
  assign flush       = w_flush    & rst;
  assign freeze      = w_freeze   & rst;
  assign state       = r_state;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (default parameters).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_inst;
  logic        id_valid;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic        branch_taken;
  logic        mem_busy;
  logic        stall;
  logic        pc_write;
  logic        idex_bubble;
  logic        flush;
  logic        freeze;
  logic [1:0]  state;
  logic [15:0] stall_count;

  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LOAD_DELAY   (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .stall        (stall),
    .pc_write     (pc_write),
    .idex_bubble  (idex_bubble),
    .flush        (flush),
    .freeze       (freeze),
    .state        (state),
    .stall_count  (stall_count)
  );

  // Pack expected {stall, pc_write, bubble, flush, freeze, state, stall_count}
  function automatic logic [22:0] E(input bit st, input bit pw, input bit bb, input bit fl,
                                    input bit fz, input logic [1:0] s, input logic [15:0] c);
    return {st, pw, bb, fl, fz, s, c};
  endfunction

  // Monitor: the controller presents outputs every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [22:0] act;
      e   = exp_q.pop_front();
      act = {stall, pc_write, idex_bubble, flush, freeze, state, stall_count};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got st=%b pw=%b bb=%b fl=%b fz=%b state=%0d cnt=%0d, expected st=%b pw=%b bb=%b fl=%b fz=%b state=%0d cnt=%0d",
                 e.name, act[22], act[21], act[20], act[19], act[18], act[17:16], act[15:0],
                 e.v[22], e.v[21], e.v[20], e.v[19], e.v[18], e.v[17:16], e.v[15:0]);
      end
    end
  end

  task automatic drive(input logic [15:0] inst, input bit idv, input bit exl,
                       input logic [3:0] exrd, input bit br, input bit mb);
    id_inst      = inst;
    id_valid     = idv;
    ex_is_load   = exl;
    ex_rd        = exrd;
    branch_taken = br;
    mem_busy     = mb;
  endtask

  // Apply one cycle of inputs, queue the expected response, advance past the edge
  task automatic cyc(input string name, input logic [15:0] inst, input bit idv, input bit exl,
                     input logic [3:0] exrd, input bit br, input bit mb, input logic [22:0] ev);
    exp_t e;
    drive(inst, idv, exl, exrd, br, mb);
    e.name = name;
    e.v    = ev;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] H  = 16'h0123;  // rs=2, rt=3
  localparam logic [15:0] SW = 16'hB105;  // store, rt=5
  localparam logic [15:0] OC = 16'hC105;  // rt=5 not read

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(16'h0, 0, 0, 4'd0, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset_state", 16'h0, 0, 0, 0, 0, 0, E(0,0,0,0,0, 2'd0, 16'd0));
    rst = 1'b1;
    cyc("reset_release", 16'h0, 0, 0, 0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd0));

    // load-use on rs, two bubble cycles
    cyc("lu_rs_c1",   H, 1, 1, 4'd2, 0, 0, E(1,0,1,0,0, 2'd0, 16'd0));
    cyc("lu_rs_c2",   0, 0, 0, 4'd0, 0, 0, E(1,0,1,0,0, 2'd1, 16'd1));
    cyc("lu_rs_done", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd2));
    cyc("lu_r0",      H, 1, 1, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd2));
    // rt source
    cyc("lu_sw_rt",   SW, 1, 1, 4'd5, 0, 0, E(1,0,1,0,0, 2'd0, 16'd2));
    cyc("lu_sw_c2",   0, 0, 0, 4'd0, 0, 0, E(1,0,1,0,0, 2'd1, 16'd3));
    cyc("lu_opc_no_rt", OC, 1, 1, 4'd5, 0, 0, E(0,1,0,0,0, 2'd0, 16'd4));
    cyc("lu_not_load", H, 1, 0, 4'd2, 0, 0, E(0,1,0,0,0, 2'd0, 16'd4));
    cyc("lu_id_invalid", H, 0, 1, 4'd2, 0, 0, E(0,1,0,0,0, 2'd0, 16'd4));
    // taken branch, second branch in FLUSH ignored
    cyc("br_c1",      0, 0, 0, 4'd0, 1, 0, E(0,1,0,1,0, 2'd0, 16'd4));
    cyc("br_c2_ign",  0, 0, 0, 4'd0, 1, 0, E(0,1,0,1,0, 2'd2, 16'd4));
    cyc("br_done",    0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd4));
    // mem_busy inside LU_STALL
    cyc("lumem_c1",   H, 1, 1, 4'd2, 0, 0, E(1,0,1,0,0, 2'd0, 16'd4));
    cyc("lumem_mb1",  0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd1, 16'd5));
    cyc("lumem_mb2",  0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd1, 16'd6));
    cyc("lumem_mb3",  0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd1, 16'd7));
    cyc("lumem_rest", 0, 0, 0, 4'd0, 0, 0, E(1,0,1,0,0, 2'd1, 16'd8));
    cyc("lumem_done", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd9));
    // all three at once in RUN
    cyc("all_mb",     H, 1, 1, 4'd2, 1, 1, E(1,0,0,0,1, 2'd0, 16'd9));
    cyc("all_memwait_exit", H, 1, 1, 4'd2, 1, 0, E(0,1,0,0,0, 2'd3, 16'd10));
    cyc("all_br_wins", H, 1, 1, 4'd2, 1, 0, E(0,1,0,1,0, 2'd0, 16'd10));
    cyc("all_flush2", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,1,0, 2'd2, 16'd10));
    cyc("all_done",   0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd10));
    // mem_busy inside FLUSH
    cyc("flmem_c1",   0, 0, 0, 4'd0, 1, 0, E(0,1,0,1,0, 2'd0, 16'd10));
    cyc("flmem_mb",   0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd2, 16'd10));
    cyc("flmem_rest", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,1,0, 2'd2, 16'd11));
    cyc("flmem_done", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd11));
    // reset in the middle of LU_STALL
    cyc("rstmid_c1",  H, 1, 1, 4'd2, 0, 0, E(1,0,1,0,0, 2'd0, 16'd11));
    rst = 1'b0;
    cyc("rstmid_same", H, 1, 1, 4'd2, 1, 1, E(0,0,0,0,0, 2'd0, 16'd0));
    cyc("rstmid_hold", 0, 0, 0, 4'd0, 0, 0, E(0,0,0,0,0, 2'd0, 16'd0));
    rst = 1'b1;
    cyc("rstmid_release", 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'd0));

    // saturation: 65534 unchecked busy cycles, then watch the counter top out
    drive(16'h0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      #1;
    end
    cyc("sat_pre",    0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd3, 16'hFFFE));
    cyc("sat_top",    0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd3, 16'hFFFF));
    cyc("sat_hold",   0, 0, 0, 4'd0, 0, 1, E(1,0,0,0,1, 2'd3, 16'hFFFF));
    cyc("sat_exit",   0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd3, 16'hFFFF));
    cyc("sat_run",    0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0, 2'd0, 16'hFFFF));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
